ysyx_041514_alu_data_buff: RTL and testbench



---
 rtl/ysyx_041514_alu_data_buff_pkg.sv | 18 +
 rtl/ysyx_041514_alu_data_buff.sv | 85 ++++++++
 tb/tb_ysyx_041514_alu_data_buff.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_041514_alu_data_buff_pkg.sv
// Shared widths, state encoding and helpers for the mul/div result buffer.
package ysyx_041514_alu_data_buff_pkg;

    localparam int DEF_XLEN     = 64;
    localparam int DEF_INST_LEN = 32;
    localparam int HIT_CNT_W    = 16;

    typedef enum logic {
        BUFF_EMPTY = 1'b0,
        BUFF_FULL  = 1'b1
    } buff_state_e;

    // Perf counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
        return (v == {HIT_CNT_W{1'b1}}) ? v : v + {{(HIT_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ysyx_041514_alu_data_buff.sv
// Holds a finished mul/div result and replays it while the same instruction
// stays stalled in EX, so the multi-cycle unit is never restarted.
module ysyx_041514_alu_data_buff
    import ysyx_041514_alu_data_buff_pkg::*;
#(
    parameter int                   XLEN        = DEF_XLEN,
    parameter int                   INST_LEN    = DEF_INST_LEN,
    // Counter value after reset; nonzero only for bring-up of the saturation path.
    parameter logic [HIT_CNT_W-1:0] HIT_CNT_RST = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_data_ready_i,
    input  logic [XLEN-1:0]      alu_data_i,
    input  logic [XLEN-1:0]      ex_pc_i,
    input  logic [INST_LEN-1:0]  ex_inst_i,
    input  logic                 ex_advance_i,
    input  logic                 flush_i,
    output logic                 alu_data_buff_valid_o,
    output logic [XLEN-1:0]      alu_data_buff_o,
    output logic [HIT_CNT_W-1:0] buff_hit_cnt_o
);

    buff_state_e          r_state;
    logic [XLEN-1:0]      r_data;
    logic [XLEN-1:0]      r_tag_pc;
    logic [INST_LEN-1:0]  r_tag_inst;
    logic [HIT_CNT_W-1:0] r_hit_cnt;

    logic w_full;
    logic w_tag_match;
    logic w_hit;

    assign w_full      = (r_state == BUFF_FULL);
    assign w_tag_match = (ex_pc_i == r_tag_pc) && (ex_inst_i == r_tag_inst);

    assign alu_data_buff_valid_o = w_full && w_tag_match && !flush_i;
    assign alu_data_buff_o       = w_full ? r_data : '0;
    assign buff_hit_cnt_o        = r_hit_cnt;

    // A replayed result retires when EX/MEM takes it while the buffer is valid.
    assign w_hit = alu_data_buff_valid_o && ex_advance_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BUFF_EMPTY;
            r_data     <= '0;
            r_tag_pc   <= '0;
            r_tag_inst <= '0;
            r_hit_cnt  <= HIT_CNT_RST;
        end else begin
            if (w_hit) begin
                r_hit_cnt <= sat_inc(r_hit_cnt);
            end

            case (r_state)
                BUFF_EMPTY: begin
                    // A result consumed in its completion cycle never needs holding.
                    if (alu_data_ready_i && !ex_advance_i && !flush_i) begin
                        r_state    <= BUFF_FULL;
                        r_data     <= alu_data_i;
                        r_tag_pc   <= ex_pc_i;
                        r_tag_inst <= ex_inst_i;
                    end
                end
                BUFF_FULL: begin
                    if (flush_i || ex_advance_i) begin
                        r_state <= BUFF_EMPTY;
                    end else if (alu_data_ready_i) begin
                        r_data     <= alu_data_i;
                        r_tag_pc   <= ex_pc_i;
                        r_tag_inst <= ex_inst_i;
                    end else if (!w_tag_match) begin
                        r_state <= BUFF_EMPTY;
                    end
                end
                default: r_state <= BUFF_EMPTY;
            endcase

            // Execute should be replaying, not recomputing, while the buffer is valid.
            assert (!(alu_data_ready_i && alu_data_buff_valid_o));
        end
    end

endmodule

// File: tb/tb_ysyx_041514_alu_data_buff.sv
// Directed bench for the mul/div result buffer: capture, replay, release paths and counter saturation.
module tb_ysyx_041514_alu_data_buff;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [63:0] data;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        adv;
    logic        flush;

    logic        valid;
    logic [63:0] buff;
    logic [15:0] hit;
    logic        sat_valid;
    logic [63:0] sat_buff;
    logic [15:0] sat_hit;

    int tests;
    int fails;

    ysyx_041514_alu_data_buff dut (
        .clk                   (clk),
        .rst                   (rst),
        .alu_data_ready_i      (ready),
        .alu_data_i            (data),
        .ex_pc_i               (pc),
        .ex_inst_i             (inst),
        .ex_advance_i          (adv),
        .flush_i               (flush),
        .alu_data_buff_valid_o (valid),
        .alu_data_buff_o       (buff),
        .buff_hit_cnt_o        (hit)
    );

    ysyx_041514_alu_data_buff #(.HIT_CNT_RST(16'hFFFE)) dut_sat (
        .clk                   (clk),
        .rst                   (rst),
        .alu_data_ready_i      (ready),
        .alu_data_i            (data),
        .ex_pc_i               (pc),
        .ex_inst_i             (inst),
        .ex_advance_i          (adv),
        .flush_i               (flush),
        .alu_data_buff_valid_o (sat_valid),
        .alu_data_buff_o       (sat_buff),
        .buff_hit_cnt_o        (sat_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a completion for pc/inst and let it be captured at the next edge.
    task automatic capture(input logic [63:0] d, input logic [63:0] p, input logic [31:0] i);
        ready = 1'b1;
        data  = d;
        pc    = p;
        inst  = i;
        tick();
        ready = 1'b0;
        data  = '0;
        #1;
        $display("[TB] capture data=%h pc=%h inst=%h -> valid=%0b buff=%h", d, p, i, valid, buff);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        ready = 1'b0;
        data  = '0;
        pc    = '0;
        inst  = '0;
        adv   = 1'b0;
        flush = 1'b0;

        tick();
        tick();
        chk("reset_valid", {63'd0, valid}, 64'd0);
        chk("reset_buff", buff, 64'd0);
        chk("reset_hit", {48'd0, hit}, 64'd0);
        chk("reset_sat_hit", {48'd0, sat_hit}, 64'h0000_0000_0000_FFFE);
        rst = 1'b0;
        #1;
        $display("[TB] reset released valid=%0b hit=%h", valid, hit);

        // Capture and replay across a stall, then retire.
        capture(64'h1234_5678_9ABC_DEF0, 64'h8000_0010, 32'h02B5_0533);
        chk("cap_valid", {63'd0, valid}, 64'd1);
        chk("cap_buff", buff, 64'h1234_5678_9ABC_DEF0);
        tick();
        chk("stall_valid", {63'd0, valid}, 64'd1);
        adv = 1'b1;
        #1;
        chk("retire_cycle_valid", {63'd0, valid}, 64'd1);
        tick();
        adv = 1'b0;
        #1;
        $display("[TB] retire -> valid=%0b buff=%h hit=%h sat_hit=%h", valid, buff, hit, sat_hit);
        chk("retire_valid", {63'd0, valid}, 64'd0);
        chk("retire_buff", buff, 64'd0);
        chk("retire_hit", {48'd0, hit}, 64'd1);
        chk("retire_sat_hit", {48'd0, sat_hit}, 64'h0000_0000_0000_FFFF);

        // Same-cycle consume: nothing is held.
        ready = 1'b1;
        adv   = 1'b1;
        data  = 64'hAAAA_BBBB_CCCC_DDDD;
        pc    = 64'h8000_0020;
        tick();
        ready = 1'b0;
        adv   = 1'b0;
        #1;
        $display("[TB] same-cycle consume -> valid=%0b buff=%h hit=%h", valid, buff, hit);
        chk("consume_valid", {63'd0, valid}, 64'd0);
        chk("consume_buff", buff, 64'd0);
        chk("consume_hit", {48'd0, hit}, 64'd1);

        // Flush beats advance and masks valid in its own cycle.
        capture(64'h0000_0000_DEAD_BEEF, 64'h8000_0030, 32'h02C5_C5B3);
        chk("flush_pre_valid", {63'd0, valid}, 64'd1);
        flush = 1'b1;
        adv   = 1'b1;
        #1;
        chk("flush_cycle_valid", {63'd0, valid}, 64'd0);
        chk("flush_cycle_buff", buff, 64'h0000_0000_DEAD_BEEF);
        tick();
        flush = 1'b0;
        adv   = 1'b0;
        #1;
        $display("[TB] flush -> valid=%0b buff=%h hit=%h", valid, buff, hit);
        chk("flush_after_valid", {63'd0, valid}, 64'd0);
        chk("flush_after_buff", buff, 64'd0);
        chk("flush_hit", {48'd0, hit}, 64'd1);

        // PC mismatch drops valid immediately and empties the buffer.
        capture(64'hFEDC_BA98_7654_3210, 64'h8000_0010, 32'h02B5_0533);
        chk("pcmis_pre_valid", {63'd0, valid}, 64'd1);
        pc = 64'h8000_0014;
        #1;
        chk("pcmis_valid", {63'd0, valid}, 64'd0);
        chk("pcmis_buff", buff, 64'hFEDC_BA98_7654_3210);
        tick();
        pc = 64'h8000_0010;
        #1;
        $display("[TB] pc mismatch -> valid=%0b buff=%h", valid, buff);
        chk("pcmis_after_valid", {63'd0, valid}, 64'd0);
        chk("pcmis_after_buff", buff, 64'd0);

        // Instruction-word mismatch alone also drops the entry.
        capture(64'h0000_0000_0000_0042, 64'h8000_0050, 32'h02B5_0533);
        inst = 32'h02B5_4533;
        #1;
        chk("instmis_valid", {63'd0, valid}, 64'd0);
        tick();
        inst = 32'h02B5_0533;
        #1;
        $display("[TB] inst mismatch -> valid=%0b buff=%h", valid, buff);
        chk("instmis_after_valid", {63'd0, valid}, 64'd0);

        // Reset while holding: no stale replay for the same EX instruction.
        capture(64'h1111_2222_3333_4444, 64'h8000_0040, 32'h02D6_06B3);
        chk("rst_pre_valid", {63'd0, valid}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        $display("[TB] reset mid-hold -> valid=%0b buff=%h hit=%h", valid, buff, hit);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_buff", buff, 64'd0);
        chk("rst_hit", {48'd0, hit}, 64'd0);
        chk("rst_sat_hit", {48'd0, sat_hit}, 64'h0000_0000_0000_FFFE);
        tick();
        chk("rst_later_valid", {63'd0, valid}, 64'd0);

        // Two replays: main counter counts, preloaded counter saturates.
        for (int k = 0; k < 2; k++) begin
            capture(64'h0000_0000_0000_0100 + 64'(k), 64'h8000_0100 + 64'(4 * k), 32'h02B5_0533);
            adv = 1'b1;
            tick();
            adv = 1'b0;
            #1;
            $display("[TB] replay %0d -> hit=%h sat_hit=%h", k, hit, sat_hit);
            chk("replay_hit", {48'd0, hit}, 64'(k + 1));
            chk("sat_hit", {48'd0, sat_hit}, 64'h0000_0000_0000_FFFF);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
